// File: rtl/fp_addsub_issuer_if.sv
// Request/response handshake bundle between the add/sub issuer and its
// upstream producer / downstream consumer.
interface fp_addsub_issuer_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_a;
    logic [31:0] in_b;
    logic [2:0]  in_ctrl;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_z;
    logic [4:0]  out_flags;

    // Issuer side.
    modport slave (
        input  in_valid, in_a, in_b, in_ctrl, out_ready,
        output in_ready, out_valid, out_z, out_flags
    );

    // Environment side (producer and consumer).
    modport master (
        output in_valid, in_a, in_b, in_ctrl, out_ready,
        input  in_ready, out_valid, out_z, out_flags
    );
endinterface

// File: rtl/fp_addsub_issuer.sv
// Credit-based issuer for a fixed-latency FP add/sub pipeline: tracks operations
// in flight, captures results into an in-order FIFO and accumulates sticky flags.
module fp_addsub_issuer #(
    parameter int LATENCY = 7,
    parameter int DEPTH   = 8
) (
    input  logic                   clk,
    input  logic                   rst,
    fp_addsub_issuer_if.slave      bus,
    output logic [31:0]            fpu_a,
    output logic [31:0]            fpu_b,
    output logic [2:0]             fpu_ctrl,
    input  logic [31:0]            fpu_z,
    input  logic [4:0]             fpu_flags,
    output logic [4:0]             sticky_flags,
    input  logic                   clr_sticky,
    output logic [$clog2(DEPTH):0] inflight
);
    localparam int PW  = $clog2(DEPTH);
    localparam int CW  = PW + 1;
    localparam int SW  = PW + 2;
    localparam int EW  = 37;

    typedef logic [EW-1:0] entry_t;

    logic [LATENCY-1:0] vld_q, vld_d;
    logic [CW-1:0]      fifo_count_q, fifo_count_d;
    logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
    entry_t             head_q, head_d;
    entry_t             mem_q [DEPTH];
    logic [4:0]         sticky_q, sticky_d;

    logic [CW-1:0]      inflight_cnt;
    logic [SW-1:0]      credit_used;
    logic               in_ready;
    logic               fire_in;
    logic               push;
    logic               pop;
    logic               empty_after_pop;
    entry_t             push_data;

    always_comb begin
        inflight_cnt = '0;
        for (int i = 0; i < LATENCY; i++) begin
            inflight_cnt = inflight_cnt + CW'(vld_q[i]);
        end
    end

    // Credit counts every result already owed a FIFO slot; a pop only frees
    // credit once it has taken effect in fifo_count.
    assign credit_used = SW'(fifo_count_q) + SW'(inflight_cnt);
    assign in_ready    = rst && (credit_used < SW'(DEPTH));
    assign fire_in     = bus.in_valid && in_ready;

    assign push      = vld_q[LATENCY-1];
    assign pop       = (fifo_count_q != '0) && bus.out_ready;
    assign push_data = {fpu_z, fpu_flags};

    assign empty_after_pop = (fifo_count_q == '0) ||
                             (pop && (fifo_count_q == CW'(1)));

    always_comb begin
        vld_d        = (vld_q << 1) | LATENCY'(fire_in);
        fifo_count_d = fifo_count_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        head_d       = head_q;
        sticky_d     = sticky_q;

        unique case ({push, pop})
            2'b10:   fifo_count_d = fifo_count_q + CW'(1);
            2'b01:   fifo_count_d = fifo_count_q - CW'(1);
            default: fifo_count_d = fifo_count_q;
        endcase

        if (push) begin
            wr_ptr_d = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end

        // Head register mirrors mem[rd_ptr]; a push into an otherwise empty
        // FIFO bypasses the array so it is visible on the next cycle.
        if (push && empty_after_pop) begin
            head_d = push_data;
        end else if (pop && !empty_after_pop) begin
            head_d = mem_q[rd_ptr_d];
        end

        if (push) begin
            sticky_d = clr_sticky ? fpu_flags : (sticky_q | fpu_flags);
        end else if (clr_sticky) begin
            sticky_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_q        <= '0;
            fifo_count_q <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            head_q       <= '0;
            sticky_q     <= '0;
        end else begin
            vld_q        <= vld_d;
            fifo_count_q <= fifo_count_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            head_q       <= head_d;
            sticky_q     <= sticky_d;
        end
    end

    // Payload storage carries no reset; validity lives in the pointers/count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= push_data;
        end
    end

    assign fpu_a         = fire_in ? bus.in_a    : '0;
    assign fpu_b         = fire_in ? bus.in_b    : '0;
    assign fpu_ctrl      = fire_in ? bus.in_ctrl : '0;

    assign bus.in_ready  = in_ready;
    assign bus.out_valid = (fifo_count_q != '0);
    assign bus.out_z     = head_q[EW-1:5];
    assign bus.out_flags = head_q[4:0];
    assign sticky_flags  = sticky_q;
    assign inflight      = inflight_cnt;
endmodule

// File: tb/tb_fp_addsub_issuer.sv
// Scoreboard bench for fp_addsub_issuer with a table-driven fixed-latency FPU stub.
module tb_fp_addsub_issuer;
    localparam int LAT = 7;
    localparam int DEP = 8;
    localparam int NV  = 9;

    localparam logic [31:0] VA [NV] = '{32'h3F800000, 32'h40400000, 32'h7F7FFFFF,
                                        32'h3F800000, 32'h40A00000, 32'h7F800000,
                                        32'h3F800000, 32'h41200000, 32'h41A00000};
    localparam logic [31:0] VB [NV] = '{32'h40000000, 32'h3F800000, 32'h7F7FFFFF,
                                        32'h3F800000, 32'hC0400000, 32'h7F800000,
                                        32'h33800000, 32'h41200000, 32'h41200000};
    localparam logic [2:0]  VC [NV] = '{3'b000, 3'b001, 3'b000, 3'b001, 3'b000,
                                        3'b001, 3'b000, 3'b000, 3'b011};
    localparam logic [31:0] VZ [NV] = '{32'h40400000, 32'h40000000, 32'h7F800000,
                                        32'h00000000, 32'h40000000, 32'h7FC00000,
                                        32'h3F800000, 32'h41A00000, 32'h41200000};
    localparam logic [4:0]  VF [NV] = '{5'b00000, 5'b00000, 5'b10001, 5'b00000,
                                        5'b00000, 5'b00010, 5'b00001, 5'b00000,
                                        5'b00000};

    logic                   clk;
    logic                   rst;
    logic [31:0]            fpu_a, fpu_b, fpu_z;
    logic [2:0]             fpu_ctrl;
    logic [4:0]             fpu_flags, sticky_flags;
    logic                   clr_sticky;
    logic [$clog2(DEP):0]   inflight;

    fp_addsub_issuer_if bif ();

    fp_addsub_issuer #(.LATENCY(LAT), .DEPTH(DEP)) dut (
        .clk          (clk),
        .rst          (rst),
        .bus          (bif.slave),
        .fpu_a        (fpu_a),
        .fpu_b        (fpu_b),
        .fpu_ctrl     (fpu_ctrl),
        .fpu_z        (fpu_z),
        .fpu_flags    (fpu_flags),
        .sticky_flags (sticky_flags),
        .clr_sticky   (clr_sticky),
        .inflight     (inflight)
    );

    int          total = 0;
    int          bad   = 0;
    logic [36:0] exp_q [$];
    int          outstanding;
    logic [LAT-1:0] hist;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [36:0] fpu_model(input logic [31:0] a, input logic [31:0] b,
                                              input logic [2:0] c);
        logic [36:0] r;
        r = {32'hDEADBEEF, 5'b11111};
        for (int i = 0; i < NV; i++) begin
            if (VA[i] == a && VB[i] == b && VC[i] == c) r = {VZ[i], VF[i]};
        end
        return r;
    endfunction

    logic [36:0] pipe [LAT];
    always @(posedge clk) begin
        pipe[0] <= fpu_model(fpu_a, fpu_b, fpu_ctrl);
        for (int i = 1; i < LAT; i++) pipe[i] <= pipe[i-1];
    end
    assign fpu_z     = pipe[LAT-1][36:5];
    assign fpu_flags = pipe[LAT-1][4:0];

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", name, got, exp, $time);
        end
    endtask

    // Monitor: per-cycle protocol model plus scoreboard pop on every accepted result.
    initial begin
        logic        fire, pop;
        logic [36:0] e;
        outstanding = 0;
        hist = '0;
        forever begin
            @(negedge clk);
            if (!rst) begin
                check("rst_in_ready", 64'(bif.in_ready), 64'(0));
                check("rst_out_valid", 64'(bif.out_valid), 64'(0));
                check("rst_inflight", 64'(inflight), 64'(0));
                outstanding = 0;
                hist = '0;
            end else begin
                fire = bif.in_valid && bif.in_ready;
                pop  = bif.out_valid && bif.out_ready;
                check("credit", 64'(bif.in_ready), 64'(outstanding < DEP));
                check("inflight", 64'(inflight), 64'($countones(hist)));
                check("out_valid", 64'(bif.out_valid),
                      64'((outstanding - $countones(hist)) != 0));
                if (fire) begin
                    check("fpu_ab", {fpu_a, fpu_b}, {bif.in_a, bif.in_b});
                    check("fpu_ctrl", 64'(fpu_ctrl), 64'(bif.in_ctrl));
                end else begin
                    check("fpu_ab_idle", {fpu_a, fpu_b}, 64'(0));
                    check("fpu_ctrl_idle", 64'(fpu_ctrl), 64'(0));
                end
                if (pop) begin
                    if (exp_q.size() == 0) begin
                        check("unexpected_result", 64'({bif.out_z, bif.out_flags}), 64'h0);
                        if ({bif.out_z, bif.out_flags} == 37'h0) begin
                            total++;
                            bad++;
                            $display("FAIL unexpected_result got=zero exp=none");
                        end
                    end else begin
                        e = exp_q.pop_front();
                        check("out_z", 64'(bif.out_z), 64'(e[36:5]));
                        check("out_flags", 64'(bif.out_flags), 64'(e[4:0]));
                    end
                end
                outstanding = outstanding + int'(fire) - int'(pop);
                check("no_overflow", 64'(outstanding <= DEP), 64'(1));
                hist = {hist[LAT-2:0], fire};
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 after the fire edge.
    task automatic send(input int id);
        int n;
        n = 0;
        bif.in_valid = 1'b1;
        bif.in_a     = VA[id];
        bif.in_b     = VB[id];
        bif.in_ctrl  = VC[id];
        @(negedge clk);
        while (!bif.in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (bif.in_ready) exp_q.push_back({VZ[id], VF[id]});
        else check("send_timeout", 64'(bif.in_ready), 64'(1));
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        bif.in_a     = '0;
        bif.in_b     = '0;
        bif.in_ctrl  = '0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        bif.out_ready = 1'b1;
        while (exp_q.size() != 0 && n < 300) begin
            n++;
            @(negedge clk);
        end
        check("drain_left", 64'(exp_q.size()), 64'(0));
        @(negedge clk);
        @(posedge clk);
        #1;
    endtask

    task automatic clr_pulse();
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        @(negedge clk);
        check("sticky_cleared", 64'(sticky_flags), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog expired t=%0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int nacc;
        int id;
        rst           = 1'b0;
        clr_sticky    = 1'b0;
        bif.in_valid  = 1'b0;
        bif.in_a      = '0;
        bif.in_b      = '0;
        bif.in_ctrl   = '0;
        bif.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", 64'(bif.out_valid), 64'(0));
        check("reset_out_z", 64'(bif.out_z), 64'(0));
        check("reset_out_flags", 64'(bif.out_flags), 64'(0));
        check("reset_sticky", 64'(sticky_flags), 64'(0));
        check("reset_inflight", 64'(inflight), 64'(0));
        check("reset_in_ready", 64'(bif.in_ready), 64'(0));
        rst = 1'b1;

        // Single op fired in the first cycle after release; head at t+LAT+1.
        send(0);
        for (int k = 1; k <= LAT; k++) begin
            @(negedge clk);
            check("lat_early", 64'(bif.out_valid), 64'(0));
        end
        @(negedge clk);
        check("lat_valid", 64'(bif.out_valid), 64'(1));
        check("lat_z", 64'(bif.out_z), 64'h40400000);
        check("lat_flags", 64'(bif.out_flags), 64'(0));
        @(posedge clk);
        #1;
        drain();

        // Sticky flags: set, persist, clear, clear coincident with a push.
        clr_pulse();
        send(2);
        drain();
        check("sticky_ovf", 64'(sticky_flags), 64'(5'b10001));
        send(0);
        drain();
        check("sticky_persist", 64'(sticky_flags), 64'(5'b10001));
        clr_pulse();
        send(2);
        drain();
        send(6);
        repeat (LAT - 1) @(posedge clk);
        #1;
        clr_sticky = 1'b1;
        @(posedge clk);
        #1;
        clr_sticky = 1'b0;
        drain();
        check("sticky_push_wins", 64'(sticky_flags), 64'(5'b00001));

        // Stream of 20 ops with the consumer always ready.
        for (int i = 0; i < 20; i++) send(i % NV);
        drain();

        // Back-pressure: exactly DEPTH ops accepted, then drained in order.
        bif.out_ready = 1'b0;
        nacc = 0;
        for (int c = 0; c < 30; c++) begin
            bif.in_valid = 1'b1;
            bif.in_a     = VA[c % NV];
            bif.in_b     = VB[c % NV];
            bif.in_ctrl  = VC[c % NV];
            @(negedge clk);
            if (bif.in_ready) begin
                exp_q.push_back({VZ[c % NV], VF[c % NV]});
                nacc++;
            end
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        check("bp_accepted", 64'(nacc), 64'(DEP));
        check("bp_in_ready", 64'(bif.in_ready), 64'(0));
        @(posedge clk);
        #1;
        bif.in_valid = 1'b0;
        drain();

        // Reset with two results buffered and three in flight.
        bif.out_ready = 1'b0;
        send(0);
        send(1);
        send(4);
        send(7);
        send(8);
        repeat (4) @(posedge clk);
        #1;
        check("pre_rst_inflight", 64'(inflight), 64'(3));
        check("pre_rst_valid", 64'(bif.out_valid), 64'(1));
        rst = 1'b0;
        exp_q.delete();
        #1;
        check("rst_mid_valid", 64'(bif.out_valid), 64'(0));
        check("rst_mid_inflight", 64'(inflight), 64'(0));
        check("rst_mid_z", 64'(bif.out_z), 64'(0));
        check("rst_mid_sticky", 64'(sticky_flags), 64'(0));
        check("rst_mid_in_ready", 64'(bif.in_ready), 64'(0));
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        bif.out_ready = 1'b1;
        send(3);
        drain();
        repeat (10) @(negedge clk);
        check("post_rst_quiet", 64'(bif.out_valid), 64'(0));
        @(posedge clk);
        #1;

        // Random traffic against the scoreboard and credit model.
        for (int c = 0; c < 10000; c++) begin
            id = $urandom_range(0, NV - 1);
            bif.in_valid  = ($urandom_range(0, 9) < 6);
            bif.in_a      = VA[id];
            bif.in_b      = VB[id];
            bif.in_ctrl   = VC[id];
            bif.out_ready = $urandom_range(0, 1) == 1;
            @(negedge clk);
            if (bif.in_valid && bif.in_ready) exp_q.push_back({VZ[id], VF[id]});
            @(posedge clk);
            #1;
        end
        bif.in_valid = 1'b0;
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
